// File: rtl/process_scheduler.sv
// -----------------------------------------------------------------------------
// process_scheduler
//
// Round-robin process scheduler for the preemptive processor. Keeps a small
// process table (init PC, final PC, saved PC, saved SP, ready flag) and counts
// retired instructions against a time quantum. When the quantum expires or the
// running process retires its final instruction, the datapath is stalled, the
// running context is saved, the next ready process is chosen round-robin and
// its PC/SP are offered to the fetch/jump logic.
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   preempt_en              1 = quantum preemption, 0 = run to completion
//   instr_valid             one instruction retired this cycle
//   run_pc, run_sp          live PC / SP of the running process
//   load_we, load_id,       table write port (init/final PC, initial SP)
//   load_init_pc,
//   load_final_pc, load_sp
//   switch_req, switch_ack  dispatch handshake (see below)
//   next_pc, next_sp        context to load on dispatch
//   hold_pc                 datapath must not retire instructions
//   current_id              running / last dispatched process
//   cur_init_pc             initial PC of current_id (relocation base)
//   idle                    no ready process
//   dbg_state, dbg_qcount   FSM state and quantum counter, for observation
//
// Handshake: switch_req rises in DISPATCH and, while it is high, next_pc,
// next_sp, current_id and cur_init_pc are stable. The transfer happens on the
// rising clk edge where switch_req and switch_ack are both 1; switch_req is low
// from the following cycle. switch_ack while switch_req is low has no effect.
// -----------------------------------------------------------------------------
module process_scheduler #(
  parameter int NUM_PROC = 4,
  parameter int TAM_PC   = 16,
  parameter int QUANTUM  = 8,
  localparam int ID_W    = $clog2(NUM_PROC),
  localparam int QW      = $clog2(QUANTUM + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              preempt_en,
  input  logic              instr_valid,
  input  logic [TAM_PC-1:0] run_pc,
  input  logic [31:0]       run_sp,
  input  logic              load_we,
  input  logic [ID_W-1:0]   load_id,
  input  logic [TAM_PC-1:0] load_init_pc,
  input  logic [TAM_PC-1:0] load_final_pc,
  input  logic [31:0]       load_sp,
  input  logic              switch_ack,
  output logic              switch_req,
  output logic [TAM_PC-1:0] next_pc,
  output logic [31:0]       next_sp,
  output logic              hold_pc,
  output logic [ID_W-1:0]   current_id,
  output logic [TAM_PC-1:0] cur_init_pc,
  output logic              idle,
  output logic [2:0]        dbg_state,
  output logic [QW-1:0]     dbg_qcount
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_SAVE     = 3'd2,
    S_SELECT   = 3'd3,
    S_DISPATCH = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic [QW-1:0] qcount_q;

  // Process table
  logic [TAM_PC-1:0] init_pc_q  [NUM_PROC];
  logic [TAM_PC-1:0] final_pc_q [NUM_PROC];
  logic [TAM_PC-1:0] saved_pc_q [NUM_PROC];
  logic [31:0]       saved_sp_q [NUM_PROC];
  logic [NUM_PROC-1:0] ready_q;

  logic is_finish, is_expiry, load_ok;
  logic sel_hit;
  logic [ID_W-1:0] sel_id, cand;

  assign is_finish = (run_pc == final_pc_q[current_id]);
  assign is_expiry = preempt_en && (qcount_q == QW'(QUANTUM - 1));
  // The running process's entry is protected from rewrites while it is live.
  assign load_ok   = load_we && ((state_q == S_IDLE) || (load_id != current_id));

  // Round-robin search: current_id+1 first, wrapping, current_id last.
  always_comb begin
    sel_hit = 1'b0;
    sel_id  = current_id;
    cand    = current_id;
    for (int i = 1; i <= NUM_PROC; i++) begin
      cand = current_id + ID_W'(i);
      if (!sel_hit && ready_q[cand]) begin
        sel_hit = 1'b1;
        sel_id  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (|ready_q) state_d = S_SELECT;
      S_RUN: begin
        if (instr_valid) begin
          // Finish takes priority: a completed process has no context to save.
          if (is_finish)      state_d = S_SELECT;
          else if (is_expiry) state_d = S_SAVE;
        end
      end
      S_SAVE:     state_d = S_SELECT;
      S_SELECT:   state_d = sel_hit ? S_DISPATCH : S_IDLE;
      S_DISPATCH: if (switch_ack) state_d = S_RUN;
      default:    state_d = S_IDLE;
    endcase
  end

  assign switch_req = (state_q == S_DISPATCH);
  assign hold_pc    = (state_q != S_RUN);
  assign idle       = (state_q == S_IDLE);
  assign dbg_state  = state_q;
  assign dbg_qcount = qcount_q;

  // FSM state, quantum counter and dispatch outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      qcount_q    <= '0;
      current_id  <= '0;
      next_pc     <= '0;
      next_sp     <= '0;
      cur_init_pc <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_RUN: begin
          if (instr_valid) begin
            if (is_finish || is_expiry || !preempt_en) qcount_q <= '0;
            else                                       qcount_q <= qcount_q + QW'(1);
          end
        end
        S_SELECT: begin
          if (sel_hit) begin
            current_id  <= sel_id;
            next_pc     <= saved_pc_q[sel_id];
            next_sp     <= saved_sp_q[sel_id];
            cur_init_pc <= init_pc_q[sel_id];
          end
        end
        S_DISPATCH: if (switch_ack) qcount_q <= '0;
        default: ;
      endcase
    end
  end

  // Process table updates. A load and a finish/save of a different entry
  // land in the same cycle without interfering.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= '0;
      for (int i = 0; i < NUM_PROC; i++) begin
        init_pc_q[i]  <= '0;
        final_pc_q[i] <= '0;
        saved_pc_q[i] <= '0;
        saved_sp_q[i] <= '0;
      end
    end else begin
      if (load_ok) begin
        init_pc_q[load_id]  <= load_init_pc;
        final_pc_q[load_id] <= load_final_pc;
        saved_pc_q[load_id] <= load_init_pc;
        saved_sp_q[load_id] <= load_sp;
        ready_q[load_id]    <= 1'b1;
      end
      if (state_q == S_RUN && instr_valid && is_finish)
        ready_q[current_id] <= 1'b0;
      if (state_q == S_SAVE) begin
        saved_pc_q[current_id] <= run_pc;
        saved_sp_q[current_id] <= run_sp;
      end
    end
  end

endmodule

// File: tb/tb_process_scheduler.sv
// -----------------------------------------------------------------------------
// tb_process_scheduler
//
// Self-checking bench for process_scheduler. Two instances share all inputs:
// u_dut (QUANTUM=8) and u_dut2 (QUANTUM=2, used for the single-process
// reselection sequence). Expected dispatches {id, init_pc, pc, sp} are pushed
// to exp_q when the stimulus that causes them is driven and popped when the
// selected instance raises switch_req.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_process_scheduler;
  localparam int SB_W = 2 + 16 + 16 + 32;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_RUN = 3'd1, ST_SAVE = 3'd2,
                         ST_SELECT = 3'd3, ST_DISPATCH = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, preempt_en, instr_valid, load_we, switch_ack;
  logic [15:0] run_pc, load_init_pc, load_final_pc;
  logic [31:0] run_sp, load_sp;
  logic [1:0]  load_id;

  logic        req1, hold1, idle1, req2, hold2, idle2;
  logic [15:0] pc1, base1, pc2, base2;
  logic [31:0] sp1, sp2;
  logic [1:0]  id1, id2;
  logic [2:0]  st1, st2;
  logic [3:0]  q1;
  logic [1:0]  q2;

  process_scheduler #(.NUM_PROC(4), .TAM_PC(16), .QUANTUM(8)) u_dut (
    .clk(clk), .reset(reset), .preempt_en(preempt_en), .instr_valid(instr_valid),
    .run_pc(run_pc), .run_sp(run_sp), .load_we(load_we), .load_id(load_id),
    .load_init_pc(load_init_pc), .load_final_pc(load_final_pc), .load_sp(load_sp),
    .switch_ack(switch_ack), .switch_req(req1), .next_pc(pc1), .next_sp(sp1),
    .hold_pc(hold1), .current_id(id1), .cur_init_pc(base1), .idle(idle1),
    .dbg_state(st1), .dbg_qcount(q1));

  process_scheduler #(.NUM_PROC(4), .TAM_PC(16), .QUANTUM(2)) u_dut2 (
    .clk(clk), .reset(reset), .preempt_en(preempt_en), .instr_valid(instr_valid),
    .run_pc(run_pc), .run_sp(run_sp), .load_we(load_we), .load_id(load_id),
    .load_init_pc(load_init_pc), .load_final_pc(load_final_pc), .load_sp(load_sp),
    .switch_ack(switch_ack), .switch_req(req2), .next_pc(pc2), .next_sp(sp2),
    .hold_pc(hold2), .current_id(id2), .cur_init_pc(base2), .idle(idle2),
    .dbg_state(st2), .dbg_qcount(q2));

  // Observed instance selector
  logic        use2 = 1'b0;
  logic        m_req, m_hold, m_idle;
  logic [15:0] m_pc, m_base;
  logic [31:0] m_sp;
  logic [1:0]  m_id;
  logic [2:0]  m_st;
  logic [3:0]  m_q;
  assign m_req  = use2 ? req2  : req1;
  assign m_hold = use2 ? hold2 : hold1;
  assign m_idle = use2 ? idle2 : idle1;
  assign m_pc   = use2 ? pc2   : pc1;
  assign m_base = use2 ? base2 : base1;
  assign m_sp   = use2 ? sp2   : sp1;
  assign m_id   = use2 ? id2   : id1;
  assign m_st   = use2 ? st2   : st1;
  assign m_q    = use2 ? {2'b00, q2} : q1;

  // ---------------- scoreboard ----------------
  logic [SB_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [15:0] base,
                          input logic [15:0] pc, input logic [31:0] sp);
    exp_q.push_back({id, base, pc, sp});
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 ns after the rising edge; outputs are checked there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instr_valid = 1'b0; load_we = 1'b0; switch_ack = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic load(input logic [1:0] id, input logic [15:0] init_pc,
                      input logic [15:0] fin_pc, input logic [31:0] sp);
    load_we = 1'b1; load_id = id;
    load_init_pc = init_pc; load_final_pc = fin_pc; load_sp = sp;
    step();
    load_we = 1'b0;
  endtask

  task automatic retire(input logic [15:0] pc);
    instr_valid = 1'b1; run_pc = pc;
    step();
    instr_valid = 1'b0;
  endtask

  // Waits (bounded) for switch_req, compares against the scoreboard for
  // 'hold' stalled cycles plus one, then acknowledges.
  task automatic dispatch_and_ack(input int hold);
    logic [SB_W-1:0] e;
    int n;
    n = 0;
    while (m_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("req_wait", m_req, 1);
    check("sb_nonempty", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k <= hold; k++) begin
        check("disp_req", m_req, 1);
        check("disp_id", m_id, e[65:64]);
        check("disp_base", m_base, e[63:48]);
        check("disp_pc", m_pc, e[47:32]);
        check("disp_sp", m_sp, e[31:0]);
        check("disp_hold", m_hold, 1);
        check("disp_qcount", m_q, 0);
        if (k < hold) begin
          instr_valid = 1'b1;   // must be ignored while stalled
          run_pc = 16'hDEAD;
          step();
        end
      end
    end
    instr_valid = 1'b0;
    switch_ack = 1'b1;
    step();
    switch_ack = 1'b0;
    check("ack_state", m_st, ST_RUN);
    check("ack_hold", m_hold, 0);
    check("ack_req", m_req, 0);
    check("ack_qcount", m_q, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  id;
    logic [15:0] init_pc;
    logic [15:0] final_pc;
    logic [31:0] sp;
    int          n_instr;
    logic [15:0] exp_pc;
    logic [31:0] exp_sp;
  } vec_t;
  vec_t vecs[3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{id: 2'd0, init_pc: 16'h0100, final_pc: 16'h0104, sp: 32'h0000_8000,
                n_instr: 5, exp_pc: 16'h0100, exp_sp: 32'h0000_8000};
    vecs[1] = '{id: 2'd2, init_pc: 16'h0200, final_pc: 16'h0200, sp: 32'h0000_9000,
                n_instr: 1, exp_pc: 16'h0200, exp_sp: 32'h0000_9000};
    vecs[2] = '{id: 2'd3, init_pc: 16'hFFF0, final_pc: 16'hFFF3, sp: 32'hFFFF_FFFC,
                n_instr: 4, exp_pc: 16'hFFF0, exp_sp: 32'hFFFF_FFFC};

    preempt_en = 1'b0; instr_valid = 1'b0; run_pc = '0; run_sp = '0;
    load_we = 1'b0; load_id = '0; load_init_pc = '0; load_final_pc = '0;
    load_sp = '0; switch_ack = 1'b0; reset = 1'b1;

    // ---- reset values ----
    do_reset();
    check("rst_state", m_st, ST_IDLE);
    check("rst_req", m_req, 0);
    check("rst_hold", m_hold, 1);
    check("rst_idle", m_idle, 1);
    check("rst_id", m_id, 0);
    check("rst_pc", m_pc, 0);
    check("rst_sp", m_sp, 0);
    check("rst_base", m_base, 0);
    check("rst_qcount", m_q, 0);

    // ---- reset in the middle of DISPATCH ----
    load(2'd1, 16'h0300, 16'h0310, 32'h0000_1234);
    for (int n = 0; n < 20 && m_req !== 1'b1; n++) step();
    check("abort_req_seen", m_req, 1);
    check("abort_pc", m_pc, 16'h0300);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_req", m_req, 0);
    check("abort_hold", m_hold, 1);
    check("abort_idle", m_idle, 1);
    for (int n = 0; n < 4; n++) begin
      step();
      check("abort_no_dispatch", m_req, 0);
      check("abort_still_idle", m_idle, 1);
    end

    // ---- table: run-to-completion processes, preemption off ----
    preempt_en = 1'b0;
    for (int v = 0; v < 3; v++) begin
      load(vecs[v].id, vecs[v].init_pc, vecs[v].final_pc, vecs[v].sp);
      push_exp(vecs[v].id, vecs[v].init_pc, vecs[v].exp_pc, vecs[v].exp_sp);
      dispatch_and_ack(0);
      for (int k = 0; k < vecs[v].n_instr; k++) begin
        retire(vecs[v].init_pc + 16'(k));
        if (k < vecs[v].n_instr - 1) begin
          check("tbl_running", m_hold, 0);
          check("tbl_qcount_off", m_q, 0);
        end
      end
      check("tbl_finish_select", m_st, ST_SELECT);
      step();
      check("tbl_idle", m_idle, 1);
      step();
      check("tbl_no_redispatch", m_req, 0);
    end

    // ---- round robin with quantum 8 ----
    do_reset();
    preempt_en = 1'b1;
    load(2'd0, 16'h0100, 16'h01FF, 32'h0000_8000);
    push_exp(2'd0, 16'h0100, 16'h0100, 32'h0000_8000);
    dispatch_and_ack(0);
    load(2'd2, 16'h0200, 16'h02FF, 32'h0000_9000);
    push_exp(2'd2, 16'h0200, 16'h0200, 32'h0000_9000);
    for (int k = 0; k < 7; k++) retire(16'h0100 + 16'(k));
    check("rr_qcount_max", m_q, 7);
    check("rr_still_run", m_hold, 0);
    retire(16'h0107);
    // T+1: SAVE. Present the context to be saved; a stray ack is ignored.
    run_pc = 16'h0108; run_sp = 32'h0000_7FF0; switch_ack = 1'b1;
    check("rr_save_state", m_st, ST_SAVE);
    check("rr_save_hold", m_hold, 1);
    check("rr_save_req", m_req, 0);
    step();
    check("rr_select_state", m_st, ST_SELECT);
    check("rr_select_req", m_req, 0);
    switch_ack = 1'b0;
    step();
    check("rr_t3_req", m_req, 1);
    push_exp(2'd0, 16'h0100, 16'h0108, 32'h0000_7FF0);
    dispatch_and_ack(0);
    // Rewrite of the running entry must be ignored.
    load(2'd2, 16'h0500, 16'h05FF, 32'h0000_0001);
    for (int k = 0; k < 8; k++) retire(16'h0200 + 16'(k));
    run_pc = 16'h0208; run_sp = 32'h0000_8FF0;
    push_exp(2'd2, 16'h0200, 16'h0208, 32'h0000_8FF0);
    step();
    step();
    // id0 resumes at its saved PC; ack withheld 5 cycles.
    dispatch_and_ack(5);
    for (int k = 0; k < 8; k++) retire(16'h0108 + 16'(k));
    run_pc = 16'h0110;
    dispatch_and_ack(0);

    // ---- finish and expiry on the same instruction ----
    do_reset();
    preempt_en = 1'b1;
    load(2'd1, 16'h0400, 16'h0407, 32'h0000_0100);
    push_exp(2'd1, 16'h0400, 16'h0400, 32'h0000_0100);
    dispatch_and_ack(0);
    load(2'd3, 16'h0600, 16'h0600, 32'h0000_0200);
    push_exp(2'd3, 16'h0600, 16'h0600, 32'h0000_0200);
    for (int k = 0; k < 8; k++) retire(16'h0400 + 16'(k));
    check("fe_no_save", m_st, ST_SELECT);
    check("fe_hold", m_hold, 1);
    step();
    check("fe_req_t2", m_req, 1);
    dispatch_and_ack(0);
    retire(16'h0600);
    step();
    check("fe_all_done_idle", m_idle, 1);
    for (int n = 0; n < 3; n++) begin
      step();
      check("fe_ready_cleared", m_req, 0);
    end

    // ---- single process, quantum 2 (second instance) ----
    do_reset();
    use2 = 1'b1;
    preempt_en = 1'b1;
    load(2'd0, 16'h0100, 16'h01FF, 32'h0000_4000);
    push_exp(2'd0, 16'h0100, 16'h0100, 32'h0000_4000);
    dispatch_and_ack(0);
    retire(16'h0100);
    check("q2_qcount", m_q, 1);
    check("q2_running", m_hold, 0);
    retire(16'h0101);
    check("q2_save", m_st, ST_SAVE);
    run_pc = 16'h0102; run_sp = 32'h0000_3FF0;
    push_exp(2'd0, 16'h0100, 16'h0102, 32'h0000_3FF0);
    step();
    step();
    check("q2_self_redispatch", m_req, 1);
    dispatch_and_ack(0);
    use2 = 1'b0;

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
